vram_access_scheduler: RTL and testbench

- Single-port VRAM sequencer for the HuC6270. One VRAM access per clock, shared between three requesters: the render fetch engine, CPU data-register traffic from the control unit, and the VRAM-to-VRAM DMA engine.
- Owns the DMA state machine: address stepping, length count and completion pulse.
- Sits between the control unit / render pipeline and the VRAM macro, which has synchronous read with 1-cycle latency.

---
 rtl/vram_access_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_vram_access_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_access_scheduler.sv
// Single-port VRAM sequencer: arbitrates render fetch, CPU data-register traffic
// and VRAM-to-VRAM DMA onto one access per clock (render > CPU > DMA).
module vram_access_scheduler #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ren_req,
   input  logic [ADDR_W-1:0] ren_addr,
   output logic [DATA_W-1:0] ren_data,
   output logic              ren_valid,
   input  logic              cpu_wr_req,
   input  logic [ADDR_W-1:0] cpu_wr_addr,
   input  logic [DATA_W-1:0] cpu_wr_data,
   input  logic              cpu_rd_req,
   input  logic [ADDR_W-1:0] cpu_rd_addr,
   output logic              cpu_busy,
   output logic [DATA_W-1:0] cpu_rd_data,
   output logic              cpu_rd_valid,
   input  logic              dma_start,
   input  logic [ADDR_W-1:0] dma_src,
   input  logic [ADDR_W-1:0] dma_dst,
   input  logic [ADDR_W-1:0] dma_len,
   input  logic              dma_src_dec,
   input  logic              dma_dst_dec,
   output logic              dma_busy,
   output logic              dma_done,
   output logic [1:0]        dma_state,
   output logic [ADDR_W-1:0] vram_addr,
   output logic              vram_we,
   output logic [DATA_W-1:0] vram_wdata,
   input  logic [DATA_W-1:0] vram_rdata
);

   typedef enum logic [1:0] {
      DMA_IDLE = 2'd0,
      DMA_RD   = 2'd1,
      DMA_WAIT = 2'd2,
      DMA_WR   = 2'd3
   } dma_state_t;

   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   dma_state_t        state_q, state_d;
   logic              wr_pend_q, rd_pend_q;
   logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic              rd_inflight_q;
   logic [DATA_W-1:0] rd_hold_q;
   logic              ren_valid_q;
   logic [ADDR_W-1:0] src_q, dst_q, cnt_q;
   logic              src_dec_q, dst_dec_q;
   logic [DATA_W-1:0] buf_q;
   logic              cpu_wr_go, cpu_rd_go, dma_slot, dma_rd_go, dma_wr_go;
   logic [ADDR_W-1:0] src_step, dst_step;

   // Request semantics: cpu_wr_req / cpu_rd_req / dma_start are single-cycle pulses
   // accepted only while the matching busy output is low; pulses seen while busy
   // are dropped. ren_req is never stalled and owns the port in the cycle it is high.
   assign cpu_busy  = wr_pend_q | rd_pend_q;
   assign cpu_wr_go = !ren_req && wr_pend_q;
   assign cpu_rd_go = !ren_req && !wr_pend_q && rd_pend_q;
   assign dma_slot  = !ren_req && !cpu_busy;
   assign dma_rd_go = dma_slot && (state_q == DMA_RD);
   assign dma_wr_go = dma_slot && (state_q == DMA_WR);
   assign src_step  = src_dec_q ? (src_q - ONE) : (src_q + ONE);
   assign dst_step  = dst_dec_q ? (dst_q - ONE) : (dst_q + ONE);

   always_comb begin
      vram_addr  = '0;
      vram_we    = 1'b0;
      vram_wdata = '0;
      if (ren_req) begin
         vram_addr = ren_addr;
      end else if (cpu_wr_go) begin
         vram_addr  = wr_addr_q;
         vram_we    = 1'b1;
         vram_wdata = wr_data_q;
      end else if (cpu_rd_go) begin
         vram_addr = rd_addr_q;
      end else if (dma_rd_go) begin
         vram_addr = src_q;
      end else if (dma_wr_go) begin
         vram_addr  = dst_q;
         vram_we    = 1'b1;
         vram_wdata = buf_q;
      end
   end

   // Read data comes straight off the macro in the return cycle; the CPU copy is
   // then held in rd_hold_q until the next CPU read returns.
   assign ren_valid    = ren_valid_q;
   assign ren_data     = ren_valid_q ? vram_rdata : '0;
   assign cpu_rd_valid = rd_inflight_q;
   assign cpu_rd_data  = rd_inflight_q ? vram_rdata : rd_hold_q;
   assign dma_busy     = (state_q != DMA_IDLE);
   assign dma_state    = state_q;

   always_comb begin
      state_d  = state_q;
      dma_done = 1'b0;
      case (state_q)
         DMA_IDLE: if (dma_start) state_d = DMA_RD;
         DMA_RD:   if (dma_rd_go) state_d = DMA_WAIT;
         DMA_WAIT: state_d = DMA_WR;
         DMA_WR: begin
            if (dma_wr_go) begin
               if (cnt_q == '0) begin
                  dma_done = 1'b1;
                  state_d  = DMA_IDLE;
               end else begin
                  state_d = DMA_RD;
               end
            end
         end
         default: state_d = DMA_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= DMA_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_pend_q     <= 1'b0;
         rd_pend_q     <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         rd_addr_q     <= '0;
         rd_inflight_q <= 1'b0;
         rd_hold_q     <= '0;
         ren_valid_q   <= 1'b0;
      end else begin
         ren_valid_q   <= ren_req;
         rd_inflight_q <= cpu_rd_go;
         if (rd_inflight_q) rd_hold_q <= vram_rdata;
         if (!cpu_busy) begin
            if (cpu_wr_req) begin
               wr_pend_q <= 1'b1;
               wr_addr_q <= cpu_wr_addr;
               wr_data_q <= cpu_wr_data;
            end
            if (cpu_rd_req) begin
               rd_pend_q <= 1'b1;
               rd_addr_q <= cpu_rd_addr;
            end
         end else begin
            if (cpu_wr_go) wr_pend_q <= 1'b0;
            if (cpu_rd_go) rd_pend_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         src_q     <= '0;
         dst_q     <= '0;
         cnt_q     <= '0;
         src_dec_q <= 1'b0;
         dst_dec_q <= 1'b0;
         buf_q     <= '0;
      end else begin
         if (state_q == DMA_IDLE && dma_start) begin
            src_q     <= dma_src;
            dst_q     <= dma_dst;
            cnt_q     <= dma_len;
            src_dec_q <= dma_src_dec;
            dst_dec_q <= dma_dst_dec;
         end
         if (state_q == DMA_WAIT) buf_q <= vram_rdata;
         if (dma_wr_go) begin
            src_q <= src_step;
            dst_q <= dst_step;
            if (cnt_q != '0) cnt_q <= cnt_q - ONE;
         end
      end
   end

endmodule

// File: tb/tb_vram_access_scheduler.sv
// Directed bench for vram_access_scheduler: per-cycle vector table for CPU/render
// traffic, hand-written sequences for DMA wrap, DMA under contention and reset abort.
module tb_vram_access_scheduler;

   localparam logic       N = 1'b0;
   localparam logic       Y = 1'b1;
   localparam logic [15:0] Z = 16'h0000;

   logic        clock = 1'b0;
   logic        reset;
   logic        ren_req;
   logic [15:0] ren_addr;
   logic [15:0] ren_data;
   logic        ren_valid;
   logic        cpu_wr_req;
   logic [15:0] cpu_wr_addr;
   logic [15:0] cpu_wr_data;
   logic        cpu_rd_req;
   logic [15:0] cpu_rd_addr;
   logic        cpu_busy;
   logic [15:0] cpu_rd_data;
   logic        cpu_rd_valid;
   logic        dma_start;
   logic [15:0] dma_src;
   logic [15:0] dma_dst;
   logic [15:0] dma_len;
   logic        dma_src_dec;
   logic        dma_dst_dec;
   logic        dma_busy;
   logic        dma_done;
   logic [1:0]  dma_state;
   logic [15:0] vram_addr;
   logic        vram_we;
   logic [15:0] vram_wdata;
   logic [15:0] vram_rdata;

   vram_access_scheduler #(.ADDR_W(16), .DATA_W(16)) dut (
      .clock(clock), .reset(reset),
      .ren_req(ren_req), .ren_addr(ren_addr), .ren_data(ren_data), .ren_valid(ren_valid),
      .cpu_wr_req(cpu_wr_req), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
      .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_busy(cpu_busy),
      .cpu_rd_data(cpu_rd_data), .cpu_rd_valid(cpu_rd_valid),
      .dma_start(dma_start), .dma_src(dma_src), .dma_dst(dma_dst), .dma_len(dma_len),
      .dma_src_dec(dma_src_dec), .dma_dst_dec(dma_dst_dec), .dma_busy(dma_busy),
      .dma_done(dma_done), .dma_state(dma_state),
      .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
      .vram_rdata(vram_rdata)
   );

   // clock / reset
   always #5 clock = ~clock;

   // VRAM macro: unwritten words read back a fixed address pattern
   function automatic logic [15:0] seed(input logic [15:0] a);
      return a ^ 16'h5A5A;
   endfunction

   logic [15:0] mem [0:65535];
   bit          written [0:65535];

   always @(posedge clock) begin
      if (vram_we) begin
         mem[vram_addr]     <= vram_wdata;
         written[vram_addr] <= 1'b1;
      end
      vram_rdata <= written[vram_addr] ? mem[vram_addr] : seed(vram_addr);
   end

   // scoreboard counters
   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", name, act, exp);
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b, want %b", name, act, exp);
   endtask

   task automatic check_zero(input string tag);
      chk1 ($sformatf("%s vram_we", tag), vram_we, N);
      chk16($sformatf("%s vram_addr", tag), vram_addr, Z);
      chk16($sformatf("%s vram_wdata", tag), vram_wdata, Z);
      chk1 ($sformatf("%s ren_valid", tag), ren_valid, N);
      chk16($sformatf("%s ren_data", tag), ren_data, Z);
      chk1 ($sformatf("%s cpu_busy", tag), cpu_busy, N);
      chk1 ($sformatf("%s cpu_rd_valid", tag), cpu_rd_valid, N);
      chk16($sformatf("%s cpu_rd_data", tag), cpu_rd_data, Z);
      chk1 ($sformatf("%s dma_busy", tag), dma_busy, N);
      chk1 ($sformatf("%s dma_done", tag), dma_done, N);
      chk16($sformatf("%s dma_state", tag), {14'd0, dma_state}, Z);
   endtask

   // vector table for CPU / render traffic
   typedef struct {
      logic        ren;
      logic [15:0] raddr;
      logic        wr;
      logic [15:0] wa;
      logic [15:0] wd;
      logic        rd;
      logic [15:0] rda;
      logic        e_we;
      logic [15:0] e_addr;
      logic [15:0] e_wd;
      logic        e_busy;
      logic        e_rv;
      logic [15:0] e_rdata;
      logic        e_cv;
      logic [15:0] e_cdata;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(
      input logic ren, input logic [15:0] raddr,
      input logic wr, input logic [15:0] wa, input logic [15:0] wd,
      input logic rd, input logic [15:0] rda,
      input logic e_we, input logic [15:0] e_addr, input logic [15:0] e_wd,
      input logic e_busy, input logic e_rv, input logic [15:0] e_rdata,
      input logic e_cv, input logic [15:0] e_cdata);
      vec_t v;
      v.ren = ren; v.raddr = raddr; v.wr = wr; v.wa = wa; v.wd = wd;
      v.rd = rd; v.rda = rda; v.e_we = e_we; v.e_addr = e_addr; v.e_wd = e_wd;
      v.e_busy = e_busy; v.e_rv = e_rv; v.e_rdata = e_rdata;
      v.e_cv = e_cv; v.e_cdata = e_cdata;
      tbl.push_back(v);
   endfunction

   // driver for DMA sequences: one cycle, inputs at negedge, outputs checked 1ns later
   task automatic dstep(input string tag, input logic ren, input logic [15:0] raddr,
                        input logic start, input logic e_we, input logic [15:0] e_addr,
                        input logic [15:0] e_wd, input logic e_busy, input logic e_done,
                        input logic e_rv, input logic [15:0] e_rd);
      @(negedge clock);
      ren_req   = ren;
      ren_addr  = raddr;
      dma_start = start;
      #1;
      chk1 ($sformatf("%s vram_we", tag), vram_we, e_we);
      chk16($sformatf("%s vram_addr", tag), vram_addr, e_addr);
      chk16($sformatf("%s vram_wdata", tag), vram_wdata, e_wd);
      chk1 ($sformatf("%s dma_busy", tag), dma_busy, e_busy);
      chk1 ($sformatf("%s dma_done", tag), dma_done, e_done);
      chk1 ($sformatf("%s ren_valid", tag), ren_valid, e_rv);
      if (e_rv) chk16($sformatf("%s ren_data", tag), ren_data, e_rd);
   endtask

   // counts dma_done pulses while armed
   logic        mon_en = 1'b0;
   logic [15:0] done_seen = 16'd0;
   always @(negedge clock) begin
      #2;
      if (mon_en && dma_done) done_seen = done_seen + 16'd1;
   end

   initial begin
      reset = 1'b1;
      ren_req = N; ren_addr = Z;
      cpu_wr_req = N; cpu_wr_addr = Z; cpu_wr_data = Z;
      cpu_rd_req = N; cpu_rd_addr = Z;
      dma_start = N; dma_src = Z; dma_dst = Z; dma_len = Z;
      dma_src_dec = N; dma_dst_dec = N;

      repeat (3) @(negedge clock);
      #1 check_zero("reset");
      @(negedge clock);
      reset = 1'b0;

      //  ren raddr        wr  wa         wd           rd  rda           we  addr       wdata        busy rv  rdata              cv  cdata
      add(N, Z,           N, Z,         Z,           N, Z,           N, Z,         Z,           N,  N, Z,                 N, Z);
      add(N, Z,           Y, 16'h1234,  16'hBEEF,    N, Z,           N, Z,         Z,           N,  N, Z,                 N, Z);
      add(N, Z,           N, Z,         Z,           N, Z,           Y, 16'h1234,  16'hBEEF,    Y,  N, Z,                 N, Z);
      add(N, Z,           N, Z,         Z,           Y, 16'h1234,    N, Z,         Z,           N,  N, Z,                 N, Z);
      add(N, Z,           N, Z,         Z,           N, Z,           N, 16'h1234,  Z,           Y,  N, Z,                 N, Z);
      add(N, Z,           N, Z,         Z,           N, Z,           N, Z,         Z,           N,  N, Z,                 Y, 16'hBEEF);
      add(Y, 16'h0200,    Y, 16'h0100,  16'h1111,    N, Z,           N, 16'h0200,  Z,           N,  N, Z,                 N, 16'hBEEF);
      add(Y, 16'h0201,    N, Z,         Z,           N, Z,           N, 16'h0201,  Z,           Y,  Y, seed(16'h0200),    N, 16'hBEEF);
      add(Y, 16'h0202,    N, Z,         Z,           N, Z,           N, 16'h0202,  Z,           Y,  Y, seed(16'h0201),    N, 16'hBEEF);
      add(Y, 16'h0203,    N, Z,         Z,           N, Z,           N, 16'h0203,  Z,           Y,  Y, seed(16'h0202),    N, 16'hBEEF);
      add(Y, 16'h0204,    N, Z,         Z,           N, Z,           N, 16'h0204,  Z,           Y,  Y, seed(16'h0203),    N, 16'hBEEF);
      add(N, Z,           N, Z,         Z,           N, Z,           Y, 16'h0100,  16'h1111,    Y,  Y, seed(16'h0204),    N, 16'hBEEF);
      add(N, Z,           N, Z,         Z,           N, Z,           N, Z,         Z,           N,  N, Z,                 N, 16'hBEEF);
      add(N, Z,           Y, 16'h0010,  16'h00AA,    Y, 16'h0010,    N, Z,         Z,           N,  N, Z,                 N, 16'hBEEF);
      add(N, Z,           N, Z,         Z,           N, Z,           Y, 16'h0010,  16'h00AA,    Y,  N, Z,                 N, 16'hBEEF);
      add(N, Z,           Y, 16'h0300,  16'h3333,    N, Z,           N, 16'h0010,  Z,           Y,  N, Z,                 N, 16'hBEEF);
      add(N, Z,           N, Z,         Z,           N, Z,           N, Z,         Z,           N,  N, Z,                 Y, 16'h00AA);
      add(N, Z,           N, Z,         Z,           N, Z,           N, Z,         Z,           N,  N, Z,                 N, 16'h00AA);
      add(N, Z,           N, Z,         Z,           Y, 16'h0100,    N, Z,         Z,           N,  N, Z,                 N, 16'h00AA);
      add(Y, 16'h0700,    N, Z,         Z,           N, Z,           N, 16'h0700,  Z,           Y,  N, Z,                 N, 16'h00AA);
      add(N, Z,           N, Z,         Z,           N, Z,           N, 16'h0100,  Z,           Y,  Y, seed(16'h0700),    N, 16'h00AA);
      add(N, Z,           N, Z,         Z,           N, Z,           N, Z,         Z,           N,  N, Z,                 Y, 16'h1111);
      add(N, Z,           N, Z,         Z,           N, Z,           N, Z,         Z,           N,  N, Z,                 N, 16'h1111);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clock);
         ren_req     = tbl[i].ren;
         ren_addr    = tbl[i].raddr;
         cpu_wr_req  = tbl[i].wr;
         cpu_wr_addr = tbl[i].wa;
         cpu_wr_data = tbl[i].wd;
         cpu_rd_req  = tbl[i].rd;
         cpu_rd_addr = tbl[i].rda;
         #1;
         chk1 ($sformatf("v%0d vram_we", i), vram_we, tbl[i].e_we);
         chk16($sformatf("v%0d vram_addr", i), vram_addr, tbl[i].e_addr);
         chk16($sformatf("v%0d vram_wdata", i), vram_wdata, tbl[i].e_wd);
         chk1 ($sformatf("v%0d cpu_busy", i), cpu_busy, tbl[i].e_busy);
         chk1 ($sformatf("v%0d ren_valid", i), ren_valid, tbl[i].e_rv);
         if (tbl[i].e_rv) chk16($sformatf("v%0d ren_data", i), ren_data, tbl[i].e_rdata);
         chk1 ($sformatf("v%0d cpu_rd_valid", i), cpu_rd_valid, tbl[i].e_cv);
         chk16($sformatf("v%0d cpu_rd_data", i), cpu_rd_data, tbl[i].e_cdata);
      end
      cpu_wr_req = N;
      cpu_rd_req = N;
      chk1("dropped write never reached vram", written[16'h0300], 1'b0);

      // DMA across the address wrap, source up, destination down
      dma_src = 16'hFFFE; dma_dst = 16'h0001; dma_len = 16'd2;
      dma_src_dec = N; dma_dst_dec = Y;
      dstep("wrap c0",  N, Z, Y, N, Z,        Z,        N, N, N, Z);
      dstep("wrap c1",  N, Z, N, N, 16'hFFFE, Z,        Y, N, N, Z);
      dstep("wrap c2",  N, Z, N, N, Z,        Z,        Y, N, N, Z);
      dstep("wrap c3",  N, Z, N, Y, 16'h0001, 16'hA5A4, Y, N, N, Z);
      dstep("wrap c4",  N, Z, N, N, 16'hFFFF, Z,        Y, N, N, Z);
      dstep("wrap c5",  N, Z, N, N, Z,        Z,        Y, N, N, Z);
      dstep("wrap c6",  N, Z, N, Y, 16'h0000, 16'hA5A5, Y, N, N, Z);
      dstep("wrap c7",  N, Z, N, N, 16'h0000, Z,        Y, N, N, Z);
      dstep("wrap c8",  N, Z, N, N, Z,        Z,        Y, N, N, Z);
      dstep("wrap c9",  N, Z, N, Y, 16'hFFFF, 16'hA5A5, Y, Y, N, Z);
      dstep("wrap c10", N, Z, N, N, Z,        Z,        N, N, N, Z);

      // DMA started inside a render burst, second start while busy
      dma_src = 16'h0400; dma_dst = 16'h0500; dma_len = 16'd1;
      dma_src_dec = N; dma_dst_dec = N;
      dstep("prs c0",  Y, 16'h0600, Y, N, 16'h0600, Z,              N, N, N, Z);
      dstep("prs c1",  Y, 16'h0601, N, N, 16'h0601, Z,              Y, N, Y, seed(16'h0600));
      dma_src = 16'h0700; dma_dst = 16'h0780; dma_len = 16'd5;
      dstep("prs c2",  Y, 16'h0602, Y, N, 16'h0602, Z,              Y, N, Y, seed(16'h0601));
      dstep("prs c3",  Y, 16'h0603, N, N, 16'h0603, Z,              Y, N, Y, seed(16'h0602));
      dstep("prs c4",  N, Z,        N, N, 16'h0400, Z,              Y, N, Y, seed(16'h0603));
      dstep("prs c5",  N, Z,        N, N, Z,        Z,              Y, N, N, Z);
      dstep("prs c6",  Y, 16'h0604, N, N, 16'h0604, Z,              Y, N, N, Z);
      dstep("prs c7",  N, Z,        N, Y, 16'h0500, seed(16'h0400), Y, N, Y, seed(16'h0604));
      dstep("prs c8",  N, Z,        N, N, 16'h0401, Z,              Y, N, N, Z);
      dstep("prs c9",  N, Z,        N, N, Z,        Z,              Y, N, N, Z);
      dstep("prs c10", N, Z,        N, Y, 16'h0501, seed(16'h0401), Y, Y, N, Z);
      dstep("prs c11", N, Z,        N, N, Z,        Z,              N, N, N, Z);
      chk16("prs mem 0500", mem[16'h0500], seed(16'h0400));
      chk16("prs mem 0501", mem[16'h0501], seed(16'h0401));
      chk1 ("prs ignored dma wrote nothing", written[16'h0780], 1'b0);

      // reset in the middle of a 4-word DMA
      dma_src = 16'h0800; dma_dst = 16'h0900; dma_len = 16'd3;
      dstep("rst c0", N, Z, Y, N, Z,        Z,              N, N, N, Z);
      dstep("rst c1", N, Z, N, N, 16'h0800, Z,              Y, N, N, Z);
      dstep("rst c2", N, Z, N, N, Z,        Z,              Y, N, N, Z);
      dstep("rst c3", N, Z, N, Y, 16'h0900, seed(16'h0800), Y, N, N, Z);
      mon_en = 1'b1;
      @(negedge clock);
      reset = 1'b1;
      #1 check_zero("abort a");
      @(negedge clock);
      #1 check_zero("abort b");
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk1("after abort dma_busy", dma_busy, N);
      repeat (12) @(negedge clock);
      mon_en = 1'b0;
      chk16("no dma_done after abort", done_seen, 16'd0);

      dma_src = 16'h0A00; dma_dst = 16'h0B00; dma_len = 16'd0;
      dstep("post c0", N, Z, Y, N, Z,        Z,              N, N, N, Z);
      dstep("post c1", N, Z, N, N, 16'h0A00, Z,              Y, N, N, Z);
      dstep("post c2", N, Z, N, N, Z,        Z,              Y, N, N, Z);
      dstep("post c3", N, Z, N, Y, 16'h0B00, seed(16'h0A00), Y, Y, N, Z);
      dstep("post c4", N, Z, N, N, Z,        Z,              N, N, N, Z);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
